// File: rtl/rv32_isa_pkg.sv
// rv32_isa_pkg: RV32I opcodes, funct codes, packer formats and the encoder operation enum
package rv32_isa_pkg;
  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
    OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
    OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;
  localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3,
    F3_XOR = 3'd4, F3_SR = 3'd5, F3_OR = 3'd6, F3_AND = 3'd7, F3_W = 3'd2;
  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE = 3'd5,
    F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;
  localparam logic [2:0] FMT_X = 3'd0, FMT_R = 3'd1, FMT_I = 3'd2, FMT_SH = 3'd3,
    FMT_S = 3'd4, FMT_B = 3'd5, FMT_U = 3'd6, FMT_J = 3'd7;
  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU,
    OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_LI
  } op_e;
endpackage

// File: rtl/rv32_encode_word.sv
// rv32_encode_word: combinational packer of one symbolic RV32I op into its machine word
module rv32_encode_word
  import rv32_isa_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        ok_o
);
  logic [2:0] fmt, f3;
  logic [6:0] opc, f7;
  always_comb begin
    {fmt, opc, f3, f7} = {FMT_X, 7'd0, 3'd0, F7_BASE};
    case (op_i)
      OP_ADD:   {fmt, opc, f3, f7} = {FMT_R, OPC_OP, F3_ADD, F7_BASE};
      OP_SUB:   {fmt, opc, f3, f7} = {FMT_R, OPC_OP, F3_ADD, F7_ALT};
      OP_AND:   {fmt, opc, f3, f7} = {FMT_R, OPC_OP, F3_AND, F7_BASE};
      OP_OR:    {fmt, opc, f3, f7} = {FMT_R, OPC_OP, F3_OR, F7_BASE};
      OP_XOR:   {fmt, opc, f3, f7} = {FMT_R, OPC_OP, F3_XOR, F7_BASE};
      OP_SLL:   {fmt, opc, f3, f7} = {FMT_R, OPC_OP, F3_SLL, F7_BASE};
      OP_SRL:   {fmt, opc, f3, f7} = {FMT_R, OPC_OP, F3_SR, F7_BASE};
      OP_SRA:   {fmt, opc, f3, f7} = {FMT_R, OPC_OP, F3_SR, F7_ALT};
      OP_SLT:   {fmt, opc, f3, f7} = {FMT_R, OPC_OP, F3_SLT, F7_BASE};
      OP_SLTU:  {fmt, opc, f3, f7} = {FMT_R, OPC_OP, F3_SLTU, F7_BASE};
      OP_ADDI:  {fmt, opc, f3, f7} = {FMT_I, OPC_OPIMM, F3_ADD, F7_BASE};
      OP_ANDI:  {fmt, opc, f3, f7} = {FMT_I, OPC_OPIMM, F3_AND, F7_BASE};
      OP_ORI:   {fmt, opc, f3, f7} = {FMT_I, OPC_OPIMM, F3_OR, F7_BASE};
      OP_XORI:  {fmt, opc, f3, f7} = {FMT_I, OPC_OPIMM, F3_XOR, F7_BASE};
      OP_SLLI:  {fmt, opc, f3, f7} = {FMT_SH, OPC_OPIMM, F3_SLL, F7_BASE};
      OP_SRLI:  {fmt, opc, f3, f7} = {FMT_SH, OPC_OPIMM, F3_SR, F7_BASE};
      OP_SRAI:  {fmt, opc, f3, f7} = {FMT_SH, OPC_OPIMM, F3_SR, F7_ALT};
      OP_SLTI:  {fmt, opc, f3, f7} = {FMT_I, OPC_OPIMM, F3_SLT, F7_BASE};
      OP_SLTIU: {fmt, opc, f3, f7} = {FMT_I, OPC_OPIMM, F3_SLTU, F7_BASE};
      OP_LW:    {fmt, opc, f3, f7} = {FMT_I, OPC_LOAD, F3_W, F7_BASE};
      OP_SW:    {fmt, opc, f3, f7} = {FMT_S, OPC_STORE, F3_W, F7_BASE};
      OP_BEQ:   {fmt, opc, f3, f7} = {FMT_B, OPC_BRANCH, F3_BEQ, F7_BASE};
      OP_BNE:   {fmt, opc, f3, f7} = {FMT_B, OPC_BRANCH, F3_BNE, F7_BASE};
      OP_BLT:   {fmt, opc, f3, f7} = {FMT_B, OPC_BRANCH, F3_BLT, F7_BASE};
      OP_BGE:   {fmt, opc, f3, f7} = {FMT_B, OPC_BRANCH, F3_BGE, F7_BASE};
      OP_BLTU:  {fmt, opc, f3, f7} = {FMT_B, OPC_BRANCH, F3_BLTU, F7_BASE};
      OP_BGEU:  {fmt, opc, f3, f7} = {FMT_B, OPC_BRANCH, F3_BGEU, F7_BASE};
      OP_JAL:   {fmt, opc, f3, f7} = {FMT_J, OPC_JAL, 3'd0, F7_BASE};
      OP_JALR:  {fmt, opc, f3, f7} = {FMT_I, OPC_JALR, 3'd0, F7_BASE};
      OP_LUI:   {fmt, opc, f3, f7} = {FMT_U, OPC_LUI, 3'd0, F7_BASE};
      OP_AUIPC: {fmt, opc, f3, f7} = {FMT_U, OPC_AUIPC, 3'd0, F7_BASE};
      default: ;
    endcase
  end
  assign ok_o = fmt != FMT_X;
  assign word_o = fmt == FMT_R  ? {f7, rs2_i, rs1_i, f3, rd_i, opc} :
                  fmt == FMT_I  ? {imm_i[11:0], rs1_i, f3, rd_i, opc} :
                  fmt == FMT_SH ? {f7, imm_i[4:0], rs1_i, f3, rd_i, opc} :
                  fmt == FMT_S  ? {imm_i[11:5], rs2_i, rs1_i, f3, imm_i[4:0], opc} :
                  fmt == FMT_B  ? {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3, imm_i[4:1], imm_i[11], opc} :
                  fmt == FMT_U  ? {imm_i[31:12], rd_i, opc} :
                  fmt == FMT_J  ? {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opc} :
                  32'd0;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I encoder with LI splitting, output register and word-address counter
module instr_encoder
  import rv32_isa_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_instr,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, HOLD, SECOND} state_e;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  state_e state_q, state_d;
  logic [31:0] instr_q, instr_d, enc_imm, enc_word;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0] lo_q, lo_d;
  logic [4:0] rd2_q, rd2_d, enc_rd, enc_rs1;
  logic [5:0] enc_op;
  logic [19:0] li_hi;
  logic err_q, err_d, enc_ok, li_op, li_small, li_two, acc, hs, sec;
  assign sec = state_q == SECOND;
  assign out_valid = state_q != IDLE;
  assign in_ready = !sec && (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  assign hs = out_valid && out_ready;
  assign li_op = in_op == OP_LI;
  assign li_small = in_imm[31:11] == '0 || in_imm[31:11] == '1;
  // rounding the upper part by bit 11 compensates for ADDI sign-extending lo
  assign li_hi = in_imm[31:12] + {19'd0, in_imm[11]};
  assign li_two = li_op && !li_small && in_imm[11:0] != 12'd0;
  // in SECOND the packer builds the staged ADDI; no request is accepted then
  assign enc_op = sec || (li_op && li_small) ? OP_ADDI : li_op ? OP_LUI : in_op;
  assign enc_rd = sec ? rd2_q : in_rd;
  assign enc_rs1 = sec ? rd2_q : li_op ? 5'd0 : in_rs1;
  assign enc_imm = sec ? {20'd0, lo_q} : li_op && !li_small ? {li_hi, 12'd0} : in_imm;
  rv32_encode_word u_enc (
    .op_i(enc_op), .rd_i(enc_rd), .rs1_i(enc_rs1), .rs2_i(in_rs2), .imm_i(enc_imm),
    .word_o(enc_word), .ok_o(enc_ok)
  );
  always_comb begin
    state_d = sec ? (hs ? HOLD : SECOND) : acc && enc_ok ? (li_two ? SECOND : HOLD) : hs ? IDLE : state_q;
    instr_d = (sec ? hs : acc && enc_ok) ? enc_word : instr_q;
    addr_d = start && state_q == IDLE ? BASE : hs ? addr_q + ADDR_W'(1) : addr_q;
    err_d = err_q || (acc && !enc_ok);
    rd2_d = acc && li_two ? in_rd : rd2_q;
    lo_d = acc && li_two ? in_imm[11:0] : lo_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= 32'd0;
      addr_q <= BASE;
      err_q <= 1'b0;
      rd2_q <= 5'd0;
      lo_q <= 12'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addr_q <= addr_d;
      err_q <= err_d;
      rd2_q <= rd2_d;
      lo_q <= lo_d;
    end
  end
  assign out_instr = instr_q;
  assign out_addr = addr_q;
  assign err = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against a queue-based reference
module tb_instr_encoder;
  import rv32_isa_pkg::*;
  logic clk = 0, rst_n = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [5:0] in_op = 0;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [31:0] in_imm = 0;
  logic in_ready, out_valid, err, w_in_ready, w_out_valid, w_err;
  logic [9:0] out_addr;
  logic [1:0] w_out_addr;
  logic [31:0] out_instr, w_out_instr;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_instr(out_instr), .err(err)
  );
  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_addr(w_out_addr), .out_instr(w_out_instr), .err(w_err)
  );

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm);
    in_valid = 1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic reset_dut;
    rst_n = 0; in_valid = 0; start = 0; out_ready = 0;
    repeat (2) tick;
    rst_n = 1;
    tick;
  endtask

  // Reference encoding built from field positions by plain shift/mask arithmetic
  function automatic logic [32:0] ref_enc(input logic [5:0] op, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm);
    logic [31:0] b, s2, ii, si, bi, ji, ui;
    b = ({27'd0, rs1} << 15) | ({27'd0, rd} << 7);
    s2 = {27'd0, rs2} << 20;
    ii = (imm & 32'hfff) << 20;
    si = (((imm >> 5) & 32'h7f) << 25) | ((imm & 32'h1f) << 7);
    bi = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7);
    ji = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21) | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12);
    ui = imm & 32'hffff_f000;
    case (op)
      OP_ADD:   return {1'b1, b | s2 | 32'h33};
      OP_SUB:   return {1'b1, b | s2 | 32'h4000_0033};
      OP_AND:   return {1'b1, b | s2 | 32'h7033};
      OP_OR:    return {1'b1, b | s2 | 32'h6033};
      OP_XOR:   return {1'b1, b | s2 | 32'h4033};
      OP_SLL:   return {1'b1, b | s2 | 32'h1033};
      OP_SRL:   return {1'b1, b | s2 | 32'h5033};
      OP_SRA:   return {1'b1, b | s2 | 32'h4000_5033};
      OP_SLT:   return {1'b1, b | s2 | 32'h2033};
      OP_SLTU:  return {1'b1, b | s2 | 32'h3033};
      OP_ADDI:  return {1'b1, b | ii | 32'h13};
      OP_ANDI:  return {1'b1, b | ii | 32'h7013};
      OP_ORI:   return {1'b1, b | ii | 32'h6013};
      OP_XORI:  return {1'b1, b | ii | 32'h4013};
      OP_SLLI:  return {1'b1, b | ((imm & 31) << 20) | 32'h1013};
      OP_SRLI:  return {1'b1, b | ((imm & 31) << 20) | 32'h5013};
      OP_SRAI:  return {1'b1, b | ((imm & 31) << 20) | 32'h4000_5013};
      OP_SLTI:  return {1'b1, b | ii | 32'h2013};
      OP_SLTIU: return {1'b1, b | ii | 32'h3013};
      OP_LW:    return {1'b1, b | ii | 32'h2003};
      OP_SW:    return {1'b1, ({27'd0, rs1} << 15) | s2 | si | 32'h2023};
      OP_BEQ:   return {1'b1, ({27'd0, rs1} << 15) | s2 | bi | 32'h0063};
      OP_BNE:   return {1'b1, ({27'd0, rs1} << 15) | s2 | bi | 32'h1063};
      OP_BLT:   return {1'b1, ({27'd0, rs1} << 15) | s2 | bi | 32'h4063};
      OP_BGE:   return {1'b1, ({27'd0, rs1} << 15) | s2 | bi | 32'h5063};
      OP_BLTU:  return {1'b1, ({27'd0, rs1} << 15) | s2 | bi | 32'h6063};
      OP_BGEU:  return {1'b1, ({27'd0, rs1} << 15) | s2 | bi | 32'h7063};
      OP_JAL:   return {1'b1, ({27'd0, rd} << 7) | ji | 32'h6f};
      OP_JALR:  return {1'b1, b | ii | 32'h67};
      OP_LUI:   return {1'b1, ({27'd0, rd} << 7) | ui | 32'h37};
      OP_AUIPC: return {1'b1, ({27'd0, rd} << 7) | ui | 32'h17};
      default:  return 33'd0;
    endcase
  endfunction

  function automatic int model(input logic [5:0] op, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm,
                               output logic [31:0] w0, output logic [31:0] w1);
    logic [32:0] r;
    logic [31:0] hi;
    w0 = 0; w1 = 0;
    if (op == OP_LI) begin
      if ($signed(imm) >= -2048 && $signed(imm) <= 2047) begin
        r = ref_enc(OP_ADDI, rd, 5'd0, 5'd0, imm); w0 = r[31:0];
        return 1;
      end
      hi = (imm + 32'h800) >> 12;
      r = ref_enc(OP_LUI, rd, 5'd0, 5'd0, hi << 12); w0 = r[31:0];
      if ((imm & 32'hfff) == 0) return 1;
      r = ref_enc(OP_ADDI, rd, rd, 5'd0, imm & 32'hfff); w1 = r[31:0];
      return 2;
    end
    r = ref_enc(op, rd, rs1, rs2, imm); w0 = r[31:0];
    return r[32] ? 1 : 0;
  endfunction

  task automatic test_reset;
    rst_n = 0;
    repeat (2) tick;
    checks++;
    if ({out_valid, out_addr, out_instr, err} !== {1'b0, 10'd0, 32'd0, 1'b0})
      begin errors++; $display("FAIL reset_state: got v=%b a=%0d i=%h e=%b want 0/0/0/0", out_valid, out_addr, out_instr, err); end
    rst_n = 1;
    tick;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_addi;
    out_ready = 1;
    drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    tick;
    in_valid = 0;
    checks++;
    if ({out_valid, out_addr, out_instr} !== {1'b1, 10'd0, 32'h00500093})
      begin errors++; $display("FAIL addi: got v=%b a=%0d i=%h want 1/0/00500093", out_valid, out_addr, out_instr); end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1; start = 1;
    drive(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    tick;
    start = 0;
    drive(OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
    checks++;
    if ({out_valid, out_addr, out_instr, in_ready} !== {1'b1, 10'd0, 32'h002081B3, 1'b1})
      begin errors++; $display("FAIL b2b_add: got v=%b a=%0d i=%h r=%b want 1/0/002081b3/1", out_valid, out_addr, out_instr, in_ready); end
    tick;
    in_valid = 0;
    checks++;
    if ({out_valid, out_addr, out_instr} !== {1'b1, 10'd1, 32'h402081B3})
      begin errors++; $display("FAIL b2b_sub: got v=%b a=%0d i=%h want 1/1/402081b3", out_valid, out_addr, out_instr); end
    tick;
  endtask

  task automatic test_li;
    logic [31:0] imms [3] = '{32'h12345678, 32'h00000800, 32'h00001000};
    logic [31:0] e0 [3] = '{32'h123452B7, 32'h000012B7, 32'h000012B7};
    logic [31:0] e1 [3] = '{32'h67828293, 32'h80028293, 32'h0};
    bit two [3] = '{1'b1, 1'b1, 1'b0};
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      start = 1;
      drive(OP_LI, 5'd5, 5'd0, 5'd0, imms[i]);
      tick;
      start = 0; in_valid = 0;
      checks++;
      if ({out_valid, out_addr, out_instr} !== {1'b1, 10'd0, e0[i]})
        begin errors++; $display("FAIL li_first[%0d]: got v=%b a=%0d i=%h want 1/0/%h", i, out_valid, out_addr, out_instr, e0[i]); end
      if (two[i]) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL li_block[%0d]: got %b want 0", i, in_ready); end
      end
      tick;
      if (two[i]) begin
        checks++;
        if ({out_valid, out_addr, out_instr, in_ready} !== {1'b1, 10'd1, e1[i], 1'b1})
          begin errors++; $display("FAIL li_second[%0d]: got v=%b a=%0d i=%h r=%b want 1/1/%h/1", i, out_valid, out_addr, out_instr, in_ready, e1[i]); end
        tick;
      end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL li_end[%0d]: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_branch_store;
    logic [5:0] ops [2] = '{OP_BEQ, OP_SW};
    logic [31:0] imms [2] = '{32'hFFFF_FFF8, 32'd12};
    logic [31:0] exp [2] = '{32'hFE208CE3, 32'h0020A623};
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      start = 1;
      drive(ops[i], 5'd7, 5'd1, 5'd2, imms[i]);
      tick;
      start = 0; in_valid = 0;
      checks++;
      if ({out_valid, out_instr} !== {1'b1, exp[i]})
        begin errors++; $display("FAIL bs[%0d]: got v=%b i=%h want 1/%h", i, out_valid, out_instr, exp[i]); end
      tick;
    end
  endtask

  task automatic test_stall;
    out_ready = 1; start = 1;
    drive(OP_XORI, 5'd4, 5'd3, 5'd0, 32'h7ff);
    tick;
    start = 0; out_ready = 0;
    drive(OP_ANDI, 5'd6, 5'd6, 5'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if ({out_valid, out_addr, out_instr, in_ready} !== {1'b1, 10'd0, 32'h7FF1C213, 1'b0})
        begin errors++; $display("FAIL stall[%0d]: got v=%b a=%0d i=%h r=%b want 1/0/7ff1c213/0", i, out_valid, out_addr, out_instr, in_ready); end
    end
    out_ready = 1;
    tick;
    in_valid = 0;
    checks++;
    if ({out_valid, out_addr, out_instr} !== {1'b1, 10'd1, 32'h00137313})
      begin errors++; $display("FAIL stall_release: got v=%b a=%0d i=%h want 1/1/00137313", out_valid, out_addr, out_instr); end
    tick;
  endtask

  task automatic test_unsupported;
    reset_dut;
    out_ready = 1;
    drive(6'd45, 5'd1, 5'd2, 5'd3, 32'd5);
    tick;
    in_valid = 0;
    checks++;
    if ({out_valid, err} !== 2'b01) begin errors++; $display("FAIL unsup: got v=%b e=%b want 0/1", out_valid, err); end
    repeat (3) tick;
    checks++;
    if ({out_valid, err} !== 2'b01) begin errors++; $display("FAIL unsup_sticky: got v=%b e=%b want 0/1", out_valid, err); end
    reset_dut;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL unsup_clear: got %b want 0", err); end
  endtask

  task automatic test_reset_mid_li;
    int seen = 0;
    out_ready = 0; start = 1;
    drive(OP_LI, 5'd5, 5'd0, 5'd0, 32'h12345678);
    tick;
    start = 0; in_valid = 0;
    checks++;
    if ({out_valid, out_instr} !== {1'b1, 32'h123452B7})
      begin errors++; $display("FAIL rli_lui: got v=%b i=%h want 1/123452b7", out_valid, out_instr); end
    rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rli_async: got %b want 0", out_valid); end
    tick;
    rst_n = 1; out_ready = 1;
    repeat (4) begin tick; if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rli_noaddi: got %0d words want 0", seen); end
  endtask

  task automatic test_start_busy;
    reset_dut;
    out_ready = 1;
    for (int i = 1; i <= 3; i++) begin drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'(i)); tick; end
    in_valid = 0; out_ready = 0; start = 1;
    repeat (2) tick;
    checks++;
    if ({out_valid, out_addr, out_instr} !== {1'b1, 10'd2, 32'h00300093})
      begin errors++; $display("FAIL start_busy_hold: got v=%b a=%0d i=%h want 1/2/00300093", out_valid, out_addr, out_instr); end
    start = 0; out_ready = 1;
    drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd4);
    tick;
    in_valid = 0;
    checks++;
    if ({out_valid, out_addr, out_instr} !== {1'b1, 10'd3, 32'h00400093})
      begin errors++; $display("FAIL start_busy_next: got v=%b a=%0d i=%h want 1/3/00400093", out_valid, out_addr, out_instr); end
    tick;
  endtask

  task automatic test_wrap;
    reset_dut;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'(i));
      tick;
      checks++;
      if ({w_out_valid, w_out_addr} !== {1'b1, 2'(i % 4)})
        begin errors++; $display("FAIL wrap[%0d]: got v=%b a=%0d want 1/%0d", i, w_out_valid, w_out_addr, i % 4); end
    end
    in_valid = 0;
    tick;
  endtask

  task automatic test_random;
    logic [31:0] q [$];
    logic [31:0] w0, w1, pi, imm;
    logic [9:0] pa;
    logic [5:0] op;
    logic [4:0] rd, rs1, rs2;
    bit ph = 0, em = 0, emp, rdy, v, ordy, st;
    int ea = 0, n;
    reset_dut;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      v = $urandom_range(0, 3) != 0;
      op = $urandom_range(0, 9) == 0 ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); imm = $urandom;
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: imm = imm & 32'hffff_f000;
        default: ;
      endcase
      ordy = $urandom_range(0, 3) != 0;
      st = $urandom_range(0, 15) == 0;
      in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      out_ready = ordy; start = st;
      #1;
      emp = q.size() == 0;
      rdy = q.size() < 2 && (emp || ordy);
      checks++;
      if ({in_ready, w_in_ready} !== {rdy, rdy})
        begin errors++; $display("FAIL rnd_ready@%0d: got %b/%b want %b", c, in_ready, w_in_ready, rdy); end
      checks++;
      if ({out_valid, w_out_valid} !== {!emp, !emp})
        begin errors++; $display("FAIL rnd_valid@%0d: got %b/%b want %b", c, out_valid, w_out_valid, !emp); end
      checks++;
      if ({err, w_err} !== {em, em})
        begin errors++; $display("FAIL rnd_err@%0d: got %b/%b want %b", c, err, w_err, em); end
      if (ph) begin
        checks++;
        if ({out_addr, out_instr} !== {pa, pi})
          begin errors++; $display("FAIL rnd_stable@%0d: got a=%0d i=%h want a=%0d i=%h", c, out_addr, out_instr, pa, pi); end
      end
      if (!emp && ordy) begin
        w0 = q.pop_front();
        checks++;
        if ({out_addr, out_instr, w_out_addr, w_out_instr} !== {10'(ea), w0, 2'(ea), w0})
          begin errors++; $display("FAIL rnd_word@%0d: got a=%0d i=%h wa=%0d wi=%h want a=%0d i=%h", c, out_addr, out_instr, w_out_addr, w_out_instr, 10'(ea), w0); end
        ea++;
      end
      ph = !emp && !ordy; pa = out_addr; pi = out_instr;
      if (st && emp) ea = 0;
      if (v && rdy) begin
        n = model(op, rd, rs1, rs2, imm, w0, w1);
        if (n == 0) em = 1;
        if (n > 0) q.push_back(w0);
        if (n > 1) q.push_back(w1);
      end
    end
    in_valid = 0; start = 0; out_ready = 1;
    repeat (3) tick;
  endtask

  initial begin
    test_reset;
    test_addi;
    test_back_to_back;
    test_li;
    test_branch_store;
    test_stall;
    test_unsupported;
    test_reset_mid_li;
    test_start_busy;
    test_wrap;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: the inverse of the control decoder. It accepts symbolic operation requests (operation, register indices, immediate) over a valid/ready handshake and emits 32-bit machine words with incrementing word addresses, ready for direct writes into instruction memory. It is used by the boot/program loader and the self-test generator. Each request produces one word, except the `LI` pseudo-op, which produces one or two words (`LUI`+`ADDI`).

## Interface
- `ADDR_W`, default 10: word-address width of instruction memory.
- `BASE_ADDR`, default 0: first word address after reset or `start`.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  restart address at `BASE_ADDR`; honoured only when idle
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request accepted when `in_valid && in_ready`
- `in_op`  in  6  operation code from package enum; see Operation
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices
- `in_imm`  in  32  immediate, two's complement
- `out_valid`  out  1  word valid
- `out_ready`  in  1  sink accepts word
- `out_addr`  out  ADDR_W  word address of `out_instr`
- `out_instr`  out  32  encoded instruction
- `err`  out  1  sticky: an unsupported `in_op` was accepted

## Operation
- Supported ops:
  - R: `ADD` `SUB` `AND` `OR` `XOR` `SLL` `SRL` `SRA` `SLT` `SLTU`
  - I: `ADDI` `ANDI` `ORI` `XORI` `SLLI` `SRLI` `SRAI` `SLTI` `SLTIU`
  - Memory: `LW` `SW`
  - Branch: `BEQ` `BNE` `BLT` `BGE` `BLTU` `BGEU`
  - Jump/upper: `JAL` `JALR` `LUI` `AUIPC`
  - Pseudo: `LI`
- Opcode, funct3 and funct7 values match those the control decoder consumes.
- Immediate slicing (unused bits are ignored and not checked):
  - I/S: `imm[11:0]`
  - Shifts: `imm[4:0]`, with funct7 `0100000` for `SRAI` and `0000000` otherwise
  - B: `imm[12:1]`
  - J: `imm[20:1]`
  - U: `imm[31:12]`
  - Unused register fields are 0.
- `LI rd, imm`:
  - If `imm` is in [-2048, 2047]: one word, `ADDI rd, x0, imm`.
  - Otherwise: `hi = (imm + 0x800) >> 12` (32-bit wrap) and `lo = imm[11:0]`. Emit `LUI rd, hi`, then `ADDI rd, rd, lo`. The `ADDI` is omitted when `lo == 0`.
- Unsupported `in_op`: the request is accepted and dropped, no word is emitted, and `err` is set. Only reset clears `err`.
- FSM:
  - `IDLE`: output register empty or draining.
  - `HOLD`: one word pending in the output register.
  - `SECOND`: `LUI` pending; the `ADDI` is staged internally.
  - Transitions:
    - `IDLE` → `HOLD` on an accepted single-word request.
    - `IDLE` → `SECOND` on an accepted two-word `LI`.
    - `SECOND` → `HOLD` when the `LUI` handshakes; the `ADDI` loads that cycle.
    - `HOLD` → `IDLE` on handshake with no new request, or `HOLD` → `HOLD`/`SECOND` on handshake plus a simultaneous accepted request.
- `in_ready = (state != SECOND) && (!out_valid || out_ready)`.
- Address: `out_addr` increments by 1 on each output handshake and wraps modulo 2^ADDR_W.
- `start`: loads `BASE_ADDR` only when `out_valid == 0` and state is `IDLE`. Otherwise it is ignored, not queued. If `start` and an accepted request coincide, the new word gets `BASE_ADDR`.

## Timing
- Reset values: `out_valid=0`, `out_instr=0`, `out_addr=BASE_ADDR`, `err=0`, state `IDLE`. `in_ready` reads 1 once `rst_n` is high.
- Latency: a request accepted at edge N presents `out_valid` after edge N (one register stage).
- Throughput: 1 word/cycle under `out_ready=1`, including back-to-back single-word requests.
- A two-word `LI` blocks input for exactly one extra cycle when `out_ready=1`.
- While `out_valid && !out_ready`, `out_instr` and `out_addr` hold stable.
- Reset asserted mid-`LI` discards the staged `ADDI`. No partial word is emitted after reset.

## Structure
- Shared package `rv32_isa_pkg` holds:
  - opcode localparams, shared with the control decoder;
  - funct3/funct7 constants;
  - the `in_op` enum.
- Sub-module `rv32_encode_word`: a combinational field packer (op, rd, rs1, rs2, imm → 32-bit word).
- `instr_encoder` contains the FSM, the `LI` split, the output register and the address counter.

## Test plan
- Reset, then `ADDI x1,x0,5` with `out_ready=1` → `out_instr=0x00500093`, `out_addr=0`, one cycle later.
- Back-to-back `ADD x3,x1,x2` and `SUB x3,x1,x2` → `0x002081B3` @0, then `0x402081B3` @1 on consecutive cycles.
- `LI x5,0x12345678` → `0x123452B7`, then `0x67828293`.
- `LI x5,0x800` → `0x000012B7`, then `0x80028293`.
- `LI x5,0x1000` → single word `0x000012B7`.
- `BEQ x1,x2,-8` → `0xFE208CE3`.
- `SW x2,12(x1)` → `0x0020A623`.
- Hold `out_ready=0` for 5 cycles → output stable and `in_ready=0`.
- Address wrap: set `ADDR_W=2` and emit 5 words → the 5th has `out_addr=0`.
- Unsupported op → no `out_valid` and `err=1`.
- Reset during `LI` `SECOND` → no `ADDI` emitted.
- `start` while busy is ignored.
